mc_apb_master: RTL and testbench
================================

// Module: mc_apb_master
// PURPOSE
//  APB initiator for the memory-controller config space; the other end of the config-register slave.
//  Turns single register requests (valid/ready) from a boot sequencer or debug port into APB SETUP/ACCESS transfers.
//  Returns read data or a timeout error on a valid/ready response channel.
//  Sits between the control/boot logic and the APB config bus, one transfer in flight at a time.
// PARAMETERS
//  DATA_WIDTH      32   APB data width (pwdata/prdata, req_wdata/rsp_rdata)
//  ADDR_WIDTH      8    APB address width
//  RDATA_DLY       1    cycles after the ACCESS completion edge before prdata is sampled (0 = standard APB)
//  TIMEOUT_CYCLES  16   ACCESS cycles with pready low before abort (>=1)
// PORTS
//  apb_pclk     in   1           clock; all logic on rising edge
//  apb_prst     in   1           synchronous, active-high reset
//  req_valid    in   1           request present
//  req_ready    out  1           request accepted when req_valid & req_ready
//  req_write    in   1           1 = write, 0 = read
//  req_addr     in   ADDR_WIDTH  register byte address
//  req_wdata    in   DATA_WIDTH  write data (ignored on reads)
//  rsp_valid    out  1           response present, held until rsp_ready
//  rsp_ready    in   1           response consumed when rsp_valid & rsp_ready
//  rsp_rdata    out  DATA_WIDTH  read data; 0 for writes and errors
//  rsp_err      out  1           1 = transfer timed out
//  busy         out  1           high in every state except IDLE
//  apb_psel     out  1           APB select
//  apb_penable  out  1           APB enable (ACCESS phase)
//  apb_pwrite   out  1           APB direction
//  apb_paddr    out  ADDR_WIDTH  APB address
//  apb_pwdata   out  DATA_WIDTH  APB write data
//  apb_pready   in   1           slave ready
//  apb_prdata   in   DATA_WIDTH  slave read data
// BEHAVIOUR
//  - Reset (sync, apb_prst=1): state IDLE; psel, penable, pwrite, rsp_valid, rsp_err, busy = 0; paddr, pwdata, rsp_rdata = 0; counters = 0.
//  - Reset mid-transfer: psel/penable drop on that edge, any pending response is discarded, no partial writeback.
//  - FSM: IDLE -> SETUP -> ACCESS -> (RDWAIT) -> RESP -> IDLE.
//  - IDLE: req_ready=1. On accept, latch write/addr/wdata into paddr/pwrite/pwdata and go to SETUP.
//  - SETUP (1 cycle): psel=1, penable=0, then go to ACCESS.
//  - ACCESS: psel=1, penable=1. paddr/pwrite/pwdata stay stable for the whole transfer.
//  - ACCESS with pready=1: the transfer completes on that edge; psel/penable=0 next cycle.
//    - Write, or RDATA_DLY=0: capture prdata (reads only; writes load 0) and go to RESP.
//    - Read with RDATA_DLY>0: go to RDWAIT.
//  - RDWAIT: count RDATA_DLY cycles, then capture apb_prdata into rsp_rdata and go to RESP.
//    This covers a slave that registers prdata on the ACCESS edge.
//  - Timeout: the wait counter increments each ACCESS cycle with pready=0.
//    When it reaches TIMEOUT_CYCLES, abort: psel/penable=0 next cycle, rsp_err=1, rsp_rdata=0, go to RESP.
//    The counter clears on entry to SETUP.
//  - RESP: rsp_valid=1 with rsp_rdata/rsp_err stable; req_ready=0.
//    On rsp_valid & rsp_ready, go to IDLE. No back-to-back transfers without one IDLE cycle.
//  - Latency with pready=1 and rsp_ready=1, counting from the accept edge:
//    write = 3 edges to rsp_valid; read = 3 + RDATA_DLY edges.
//  - paddr/pwdata/pwrite hold their last value in IDLE; they are not cleared.
//  - req_* inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.
//  - Counter widths are $clog2(TIMEOUT_CYCLES+1) and $clog2(RDATA_DLY+1), minimum 1 bit; the counters never wrap.
// STRUCTURE
//  - Shared defines header mc_apb_defs.vh: FSM state encodings (IDLE, SETUP, ACCESS, RDWAIT, RESP) and the APB address map constants (0x00..0x18), reused by the slave and by benches.
//  - Single flat module; no sub-module is warranted.
//  - Bench pairs this block with the config-register slave and a stall/monitor model.
// TESTING
//  - Write 0x08 <- 0x00160610 against the config slave:
//    SETUP psel=1/penable=0, next cycle penable=1, rsp_valid 3 edges after accept, rsp_err=0; slave tRAS=0x10, tRP=0x06, tRC=0x16.
//  - Read 0x0C after reset, RDATA_DLY=1: rsp_rdata=0x03060707 at 4 edges after accept.
//    The same read with RDATA_DLY=0 returns the stale prdata (0), which confirms the delay is needed.
//  - Model holds pready=0 for 5 cycles on a write to 0x00 <- 1: ACCESS lasts 6 cycles, paddr/pwdata stable throughout, rsp_err=0, mc_en=1.
//  - pready held 0, TIMEOUT_CYCLES=16: abort after 16 ACCESS cycles, psel drops, rsp_valid=1, rsp_err=1, rsp_rdata=0.
//  - rsp_ready held 0 for 10 cycles with a second req_valid pending: rsp_valid and data stay stable, req_ready=0.
//    The second request is accepted one cycle after the response handshake.
//  - Assert apb_prst during ACCESS: psel/penable=0 next cycle, no rsp_valid, req_ready=1, outputs at reset values.

Source files
------------

// File: rtl/mc_apb_master_pkg.sv
// Shared types for the memory-controller APB initiator: FSM states, config-space
// address map and the counter-width helper used to size the wait/delay counters.
package mc_apb_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_RDWAIT = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  // Config-register byte addresses, shared with the config slave and benches.
  typedef enum logic [7:0] {
    MC_REG_CTRL     = 8'h00,
    MC_REG_STATUS   = 8'h04,
    MC_REG_TRAS_TRP = 8'h08,
    MC_REG_TIMING   = 8'h0C,
    MC_REG_REFRESH  = 8'h10,
    MC_REG_MODE     = 8'h14,
    MC_REG_DEBUG    = 8'h18
  } mc_reg_addr_e;

  typedef struct packed {
    logic [7:0] rsvd;
    logic [7:0] trc;
    logic [7:0] trp;
    logic [7:0] tras;
  } mc_tras_trp_t;

  // Bits needed to hold 0..n inclusive, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/mc_apb_master_if.sv
// Request/response channels plus the APB config bus for mc_apb_master.
// The master modport is the initiator's view; slave is the environment's view.
interface mc_apb_master_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  logic                  busy;

  logic                  apb_psel;
  logic                  apb_penable;
  logic                  apb_pwrite;
  logic [ADDR_WIDTH-1:0] apb_paddr;
  logic [DATA_WIDTH-1:0] apb_pwdata;
  logic                  apb_pready;
  logic [DATA_WIDTH-1:0] apb_prdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output busy,
    output apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
    input  apb_pready, apb_prdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  busy,
    input  apb_psel, apb_penable, apb_pwrite, apb_paddr, apb_pwdata,
    output apb_pready, apb_prdata
  );

endinterface

// File: rtl/mc_apb_master.sv
// APB initiator for the memory-controller config space: one register request at a
// time becomes a SETUP/ACCESS transfer, answered with read data or a timeout error.
module mc_apb_master
  import mc_apb_master_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned RDATA_DLY      = 1,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic             apb_pclk,
  input logic             apb_prst,
  mc_apb_master_if.master bus
);

  localparam int unsigned WAIT_W = cnt_width(TIMEOUT_CYCLES);
  localparam int unsigned DLY_W  = cnt_width(RDATA_DLY);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DLY_W-1:0]  DLY_LAST  = DLY_W'((RDATA_DLY > 0) ? RDATA_DLY - 1 : 0);

  state_e                state_q,     state_d;
  logic                  psel_q,      psel_d;
  logic                  penable_q,   penable_d;
  logic                  pwrite_q,    pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q,   rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [WAIT_W-1:0]     wait_cnt_q,  wait_cnt_d;
  logic [DLY_W-1:0]      dly_cnt_q,   dly_cnt_d;

  always_comb begin
    // NOTE: every _d starts from its _q, so no path through this block infers a latch.
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    wait_cnt_d  = wait_cnt_q;
    dly_cnt_d   = dly_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          pwrite_d   = bus.req_write;
          paddr_d    = bus.req_addr;
          pwdata_d   = bus.req_wdata;
          psel_d     = 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (bus.apb_pready) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (pwrite_q || RDATA_DLY == 0) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = pwrite_q ? '0 : bus.apb_prdata;
            state_d     = ST_RESP;
          end else begin
            dly_cnt_d = '0;
            state_d   = ST_RDWAIT;
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Slave never answered: abort the transfer and report it as an error.
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          wait_cnt_d  = wait_cnt_q + 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      // The slave registers prdata on the completion edge, so sample it late.
      ST_RDWAIT: begin
        if (dly_cnt_q == DLY_LAST) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = bus.apb_prdata;
          state_d     = ST_RESP;
        end else begin
          dly_cnt_d = dly_cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge apb_pclk) begin
    if (apb_prst) begin
      state_q     <= ST_IDLE;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      wait_cnt_q  <= '0;
      dly_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      wait_cnt_q  <= wait_cnt_d;
      dly_cnt_q   <= dly_cnt_d;
    end
  end

  assign bus.req_ready   = (state_q == ST_IDLE);
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.apb_psel    = psel_q;
  assign bus.apb_penable = penable_q;
  assign bus.apb_pwrite  = pwrite_q;
  assign bus.apb_paddr   = paddr_q;
  assign bus.apb_pwdata  = pwdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_rdata   = rsp_rdata_q;

endmodule

// File: tb/tb_mc_apb_master.sv
// Directed bench for mc_apb_master: a config-register slave with stall control,
// a table of single transfers, and hand-written multi-cycle corner cases.
module tb_mc_apb_master;
  import mc_apb_master_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_apb_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus  ();
  mc_apb_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus0 ();

  mc_apb_master #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RDATA_DLY(1), .TIMEOUT_CYCLES(16)) u_dut (
    .apb_pclk (clk),
    .apb_prst (rst),
    .bus      (bus)
  );

  mc_apb_master #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RDATA_DLY(0), .TIMEOUT_CYCLES(16)) u_dut0 (
    .apb_pclk (clk),
    .apb_prst (rst),
    .bus      (bus0)
  );

  // Config slave: registers prdata on the completion edge, stalls stall_n cycles.
  logic [31:0] regs [8];
  logic [31:0] prdata_q;
  int          acc_cnt;
  int          stall_n = 0;
  bit          hang = 1'b0;

  assign bus.apb_pready = !hang && (acc_cnt >= stall_n);
  assign bus.apb_prdata = prdata_q;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= (i == 3) ? 32'h0306_0707 : 32'h0;
      prdata_q <= '0;
      acc_cnt  <= 0;
    end else if (bus.apb_psel && bus.apb_penable) begin
      if (bus.apb_pready) begin
        acc_cnt <= 0;
        if (bus.apb_pwrite) regs[bus.apb_paddr[4:2]] <= bus.apb_pwdata;
        else                prdata_q <= regs[bus.apb_paddr[4:2]];
      end else begin
        acc_cnt <= acc_cnt + 1;
      end
    end else begin
      acc_cnt <= 0;
    end
  end

  // Minimal slave for the RDATA_DLY=0 instance: always ready, registered data.
  logic [31:0] prdata0_q;
  assign bus0.apb_pready = 1'b1;
  assign bus0.apb_prdata = prdata0_q;
  always @(posedge clk) begin
    if (rst) prdata0_q <= '0;
    else if (bus0.apb_psel && bus0.apb_penable) prdata0_q <= 32'h0306_0707;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transfer on bus; lat counts edges from acceptance to rsp_valid.
  task automatic do_xfer(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    tick();
    lat = 1;
    bus.req_valid = 1'b0;
    while (!bus.rsp_valid && lat < 200) begin
      tick();
      lat++;
    end
    rdata = bus.rsp_rdata;
    err   = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          stall;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [31:0]  rdata;
    logic         err;
    int           lat;
    int           acc;
    bit           ok;
    mc_tras_trp_t tt;

    vecs[0]  = '{1'b0, MC_REG_TIMING,   32'h0,          0, 32'h0306_0707, 1'b0, 4};
    vecs[1]  = '{1'b1, MC_REG_TRAS_TRP, 32'h0016_0610, 0, 32'h0,          1'b0, 3};
    vecs[2]  = '{1'b0, MC_REG_TRAS_TRP, 32'h0,          0, 32'h0016_0610, 1'b0, 4};
    vecs[3]  = '{1'b1, MC_REG_CTRL,     32'h0000_0001, 5, 32'h0,          1'b0, 8};
    vecs[4]  = '{1'b0, MC_REG_CTRL,     32'h0,          0, 32'h0000_0001, 1'b0, 4};
    vecs[5]  = '{1'b1, MC_REG_MODE,     32'hA5A5_5A5A, 2, 32'h0,          1'b0, 5};
    vecs[6]  = '{1'b0, MC_REG_MODE,     32'h0,          3, 32'hA5A5_5A5A, 1'b0, 7};
    vecs[7]  = '{1'b0, MC_REG_DEBUG,    32'h0,          0, 32'h0,          1'b0, 4};
    vecs[8]  = '{1'b1, MC_REG_DEBUG,    32'hFFFF_FFFF, 0, 32'h0,          1'b0, 3};
    vecs[9]  = '{1'b0, MC_REG_DEBUG,    32'h0,          0, 32'hFFFF_FFFF, 1'b0, 4};
    vecs[10] = '{1'b0, MC_REG_TIMING,   32'h0,         15, 32'h0306_0707, 1'b0, 19};

    bus.req_valid  = 1'b0; bus.req_write  = 1'b0; bus.req_addr  = '0; bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b0;
    bus0.req_valid = 1'b0; bus0.req_write = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
    bus0.rsp_ready = 1'b0;

    rst = 1'b1;
    tick(); tick();
    check("reset psel",      bus.apb_psel,    1'b0);
    check("reset penable",   bus.apb_penable, 1'b0);
    check("reset pwrite",    bus.apb_pwrite,  1'b0);
    check("reset paddr",     bus.apb_paddr,   8'h00);
    check("reset pwdata",    bus.apb_pwdata,  32'h0);
    check("reset rsp_valid", bus.rsp_valid,   1'b0);
    check("reset rsp_err",   bus.rsp_err,     1'b0);
    check("reset rsp_rdata", bus.rsp_rdata,   32'h0);
    check("reset busy",      bus.busy,        1'b0);
    check("reset req_ready", bus.req_ready,   1'b1);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) begin
      stall_n = vecs[i].stall;
      do_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rdata, err, lat);
      check($sformatf("vec%0d rdata", i),   rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d err", i),     err,   vecs[i].exp_err);
      check($sformatf("vec%0d latency", i), lat,   vecs[i].exp_lat);
    end
    stall_n = 0;

    tt = regs[2];
    check("slave tRAS", tt.tras, 8'h10);
    check("slave tRP",  tt.trp,  8'h06);
    check("slave tRC",  tt.trc,  8'h16);

    // Phase-by-phase write timing.
    bus.req_valid = 1'b1; bus.req_write = 1'b1;
    bus.req_addr = MC_REG_REFRESH; bus.req_wdata = 32'h1234_5678;
    tick();
    bus.req_valid = 1'b0;
    check("setup psel",      bus.apb_psel,    1'b1);
    check("setup penable",   bus.apb_penable, 1'b0);
    check("setup paddr",     bus.apb_paddr,   8'h10);
    check("setup req_ready", bus.req_ready,   1'b0);
    check("setup busy",      bus.busy,        1'b1);
    tick();
    check("access psel",     bus.apb_psel,    1'b1);
    check("access penable",  bus.apb_penable, 1'b1);
    tick();
    check("wr rsp_valid",    bus.rsp_valid,   1'b1);
    check("wr psel drop",    bus.apb_psel,    1'b0);
    check("wr pwdata",       bus.apb_pwdata,  32'h1234_5678);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("idle busy",       bus.busy,        1'b0);
    check("idle paddr held", bus.apb_paddr,   8'h10);

    // Stalled write: ACCESS spans 6 cycles with a stable address phase.
    stall_n = 5;
    bus.req_valid = 1'b1; bus.req_write = 1'b1;
    bus.req_addr = MC_REG_CTRL; bus.req_wdata = 32'h0000_0001;
    tick();
    bus.req_valid = 1'b0;
    tick();
    acc = 0; ok = 1'b1;
    while (bus.apb_psel && bus.apb_penable && acc < 100) begin
      acc++;
      if (bus.apb_paddr !== 8'h00 || bus.apb_pwdata !== 32'h1 || bus.apb_pwrite !== 1'b1) ok = 1'b0;
      tick();
    end
    check("stall access cycles", acc, 6);
    check("stall addr stable",   ok,  1'b1);
    check("stall rsp_valid",     bus.rsp_valid, 1'b1);
    check("stall rsp_err",       bus.rsp_err,   1'b0);
    bus.rsp_ready = 1'b1; tick(); bus.rsp_ready = 1'b0;
    check("stall mc_en", regs[0][0], 1'b1);
    stall_n = 0;

    // Timeout: pready never rises on a read.
    hang = 1'b1;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = MC_REG_TIMING;
    tick();
    bus.req_valid = 1'b0;
    tick();
    acc = 0;
    while (bus.apb_psel && bus.apb_penable && acc < 100) begin
      acc++;
      tick();
    end
    check("timeout access cycles", acc, 16);
    check("timeout psel",      bus.apb_psel,  1'b0);
    check("timeout rsp_valid", bus.rsp_valid, 1'b1);
    check("timeout rsp_err",   bus.rsp_err,   1'b1);
    check("timeout rsp_rdata", bus.rsp_rdata, 32'h0);
    hang = 1'b0;
    bus.rsp_ready = 1'b1; tick(); bus.rsp_ready = 1'b0;

    // Response backpressure with a second request waiting.
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = MC_REG_TIMING;
    tick();
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 50) begin tick(); lat++; end
    check("bp rsp_valid", bus.rsp_valid, 1'b1);
    bus.req_valid = 1'b1; bus.req_write = 1'b1;
    bus.req_addr = MC_REG_MODE; bus.req_wdata = 32'h0BAD_F00D;
    ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (!bus.rsp_valid || bus.rsp_rdata !== 32'h0306_0707 || bus.rsp_err ||
          bus.req_ready || bus.apb_psel) ok = 1'b0;
      tick();
    end
    check("bp response held", ok, 1'b1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("bp idle rsp_valid", bus.rsp_valid, 1'b0);
    check("bp idle req_ready", bus.req_ready, 1'b1);
    check("bp idle psel",      bus.apb_psel,  1'b0);
    tick();
    bus.req_valid = 1'b0;
    check("bp second accepted", bus.apb_psel,  1'b1);
    check("bp second paddr",    bus.apb_paddr, 8'h14);
    lat = 0;
    while (!bus.rsp_valid && lat < 50) begin tick(); lat++; end
    bus.rsp_ready = 1'b1; tick(); bus.rsp_ready = 1'b0;
    check("bp second written", regs[5], 32'h0BAD_F00D);

    // Reset during ACCESS.
    hang = 1'b1;
    bus.req_valid = 1'b1; bus.req_write = 1'b1;
    bus.req_addr = MC_REG_DEBUG; bus.req_wdata = 32'h1111_1111;
    tick();
    bus.req_valid = 1'b0;
    tick(); tick();
    check("pre-reset penable", bus.apb_penable, 1'b1);
    rst = 1'b1;
    hang = 1'b0;
    tick();
    check("midrst psel",      bus.apb_psel,    1'b0);
    check("midrst penable",   bus.apb_penable, 1'b0);
    check("midrst rsp_valid", bus.rsp_valid,   1'b0);
    check("midrst req_ready", bus.req_ready,   1'b1);
    check("midrst busy",      bus.busy,        1'b0);
    check("midrst paddr",     bus.apb_paddr,   8'h00);
    check("midrst pwdata",    bus.apb_pwdata,  32'h0);
    rst = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.rsp_valid || bus.apb_psel || !bus.req_ready) ok = 1'b0;
    end
    check("postrst quiet", ok, 1'b1);

    // RDATA_DLY=0 against a registered-prdata slave returns stale data first.
    for (int k = 0; k < 2; k++) begin
      bus0.req_valid = 1'b1; bus0.req_write = 1'b0; bus0.req_addr = MC_REG_TIMING;
      tick();
      bus0.req_valid = 1'b0;
      lat = 1;
      while (!bus0.rsp_valid && lat < 50) begin tick(); lat++; end
      check($sformatf("dly0 rd%0d latency", k), lat, 3);
      check($sformatf("dly0 rd%0d rdata", k), bus0.rsp_rdata,
            (k == 0) ? 32'h0 : 32'h0306_0707);
      bus0.rsp_ready = 1'b1; tick(); bus0.rsp_ready = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
